// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external combinational ALU between two requesters
// (0: pipeline EX, 1: aux/address unit). Round-robin grant, one op in flight, result and
// equal flag registered and held on a per-requester response channel until consumed.
//
// Ports:
//   clk, reset               clock and synchronous active-high reset
//   req_valid/req_ready      per-requester request handshake (bit k = requester k)
//   req_a/req_b              {r1,r0} operands, WIDTH bits each
//   req_shamt/req_op         {r1,r0} 5-bit shift amount / 3-bit ALU op
//   alu_a/b/shamt/op         operand bus to the external ALU (zero when nothing granted)
//   alu_result/alu_equal     combinational ALU outputs
//   resp_valid/resp_ready    one-hot response handshake for the owning requester
//   resp_result/resp_equal   registered ALU outputs
//   grant_cnt0/grant_cnt1    saturating grant counters
//
// Optional feature: define ALU_ARB_STATS_EN to build the grant counters; otherwise the
// counter outputs are tied to zero.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [9:0]         req_shamt,
  input  logic [5:0]         req_op,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [4:0]         alu_shamt,
  output logic [2:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_equal,
  output logic [1:0]         resp_valid,
  input  logic [1:0]         resp_ready,
  output logic [WIDTH-1:0]   resp_result,
  output logic               resp_equal,
  output logic [CNT_W-1:0]   grant_cnt0,
  output logic [CNT_W-1:0]   grant_cnt1
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StResp = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [1:0]       resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_result_q, resp_result_d;
  logic             resp_equal_q, resp_equal_d;
  logic             last_grant_q, last_grant_d;

  logic gnt_idx;
  logic grant;
  logic resp_done;

  // Grant selection and ALU operand bus.
  always_comb begin
    gnt_idx = req_valid[1];
    if (req_valid == 2'b11) begin
      gnt_idx = ~last_grant_q;
    end
    // req_ready only ever asserts for a valid requester, so grant is the handshake.
    grant     = (state_q == StIdle) && (|req_valid);
    req_ready = 2'b00;
    alu_a     = '0;
    alu_b     = '0;
    alu_shamt = '0;
    alu_op    = '0;
    if (grant) begin
      req_ready = gnt_idx ? 2'b10 : 2'b01;
      if (gnt_idx) begin
        alu_a     = req_a[2*WIDTH-1:WIDTH];
        alu_b     = req_b[2*WIDTH-1:WIDTH];
        alu_shamt = req_shamt[9:5];
        alu_op    = req_op[5:3];
      end else begin
        alu_a     = req_a[WIDTH-1:0];
        alu_b     = req_b[WIDTH-1:0];
        alu_shamt = req_shamt[4:0];
        alu_op    = req_op[2:0];
      end
    end
  end

  // Only the owner's resp_ready can retire the response.
  assign resp_done = (state_q == StResp) && (|(resp_valid_q & resp_ready));

  always_comb begin
    state_d       = state_q;
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_equal_d  = resp_equal_q;
    last_grant_d  = last_grant_q;
    if (grant) begin
      state_d       = StResp;
      resp_valid_d  = gnt_idx ? 2'b10 : 2'b01;
      resp_result_d = alu_result;
      resp_equal_d  = alu_equal;
      last_grant_d  = gnt_idx;
    end else if (resp_done) begin
      state_d      = StIdle;
      resp_valid_d = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      resp_valid_q  <= 2'b00;
      resp_result_q <= '0;
      resp_equal_q  <= 1'b0;
      last_grant_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_equal_q  <= resp_equal_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_equal  = resp_equal_q;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Saturating at all-ones so the counters never wrap.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (grant && !gnt_idx && (cnt0_q != '1)) begin
      cnt0_d = cnt0_q + CNT_W'(1);
    end
    if (grant && gnt_idx && (cnt1_q != '1)) begin
      cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 2;

  logic               clk;
  logic               reset;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [9:0]         req_shamt;
  logic [5:0]         req_op;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [4:0]         alu_shamt;
  logic [2:0]         alu_op;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_equal;
  logic [1:0]         resp_valid;
  logic [1:0]         resp_ready;
  logic [WIDTH-1:0]   resp_result;
  logic               resp_equal;
  logic [CNT_W-1:0]   grant_cnt0;
  logic [CNT_W-1:0]   grant_cnt1;

  int n_cmp;
  int n_err;

  alu_share_arbiter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_shamt  (req_shamt),
    .req_op     (req_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_shamt  (alu_shamt),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_equal  (alu_equal),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_result(resp_result),
    .resp_equal (resp_equal),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU model: lui shifts b into the upper half, sll shifts b by shamt.
  always_comb begin
    case (alu_op)
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = alu_a & alu_b;
      3'd3:    alu_result = alu_a | alu_b;
      3'd4:    alu_result = alu_b << alu_shamt;
      3'd5:    alu_result = alu_b << 16;
      default: alu_result = '0;
    endcase
    alu_equal = (alu_a == alu_b);
  end

  task automatic clear_inputs();
    req_valid  = 2'b00;
    req_a      = '0;
    req_b      = '0;
    req_shamt  = '0;
    req_op     = '0;
    resp_ready = 2'b00;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (resp_valid !== 2'b00) begin
      n_err++; $display("FAIL reset_resp_valid: got %b want 00", resp_valid);
    end
    n_cmp++;
    if (resp_result !== '0) begin
      n_err++; $display("FAIL reset_resp_result: got %h want 0", resp_result);
    end
    n_cmp++;
    if (resp_equal !== 1'b0) begin
      n_err++; $display("FAIL reset_resp_equal: got %b want 0", resp_equal);
    end
    n_cmp++;
    if (req_ready !== 2'b00 || alu_a !== '0 || alu_op !== 3'd0) begin
      n_err++;
      $display("FAIL reset_idle_bus: ready %b a %h op %0d want 00/0/0", req_ready, alu_a, alu_op);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid = 2'b01;
    req_a[31:0] = 32'd5;
    req_b[31:0] = 32'd3;
    req_op[2:0] = 3'd0;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL single_req_ready: got %b want 01", req_ready);
    end
    n_cmp++;
    if (alu_a !== 32'd5 || alu_b !== 32'd3) begin
      n_err++; $display("FAIL single_alu_ops: got a=%h b=%h want 5/3", alu_a, alu_b);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    n_cmp++;
    if (resp_valid !== 2'b01 || resp_result !== 32'd8 || resp_equal !== 1'b0) begin
      n_err++;
      $display("FAIL single_resp: got v=%b r=%h e=%b want 01/8/0",
               resp_valid, resp_result, resp_equal);
    end
    resp_ready = 2'b01;
    @(posedge clk); #1;
    resp_ready = 2'b00;
    n_cmp++;
    if (resp_valid !== 2'b00) begin
      n_err++; $display("FAIL single_consume: got %b want 00", resp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [WIDTH-1:0] exp_res;
    apply_reset();
    req_a      = {32'd0, 32'd10};
    req_b      = {32'h1234, 32'd4};
    req_op     = {3'd5, 3'd1};
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_res = (i % 2 == 0) ? 32'd6 : 32'h1234_0000;
      n_cmp++;
      if (req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_err++; $display("FAIL rr_grant_%0d: got %b", i, req_ready);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (resp_valid !== ((i % 2 == 0) ? 2'b01 : 2'b10) || resp_result !== exp_res) begin
        n_err++;
        $display("FAIL rr_resp_%0d: got v=%b r=%h want r=%h", i, resp_valid, resp_result, exp_res);
      end
      @(posedge clk);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_hold();
    @(negedge clk);
    req_valid = 2'b10;
    req_b[63:32] = 32'd1;
    req_shamt[9:5] = 5'd4;
    req_op[5:3] = 3'd4;
    #1;
    n_cmp++;
    if (req_ready !== 2'b10 || alu_shamt !== 5'd4 || alu_op !== 3'd4) begin
      n_err++;
      $display("FAIL hold_grant: ready %b shamt %0d op %0d want 10/4/4", req_ready, alu_shamt, alu_op);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (resp_valid !== 2'b10 || resp_result !== 32'd16 || req_ready !== 2'b00 ||
          alu_a !== '0 || alu_b !== '0 || alu_shamt !== '0 || alu_op !== '0) begin
        n_err++;
        $display("FAIL hold_cycle_%0d: v=%b r=%h ready=%b b=%h shamt=%0d op=%0d", i,
                 resp_valid, resp_result, req_ready, alu_b, alu_shamt, alu_op);
      end
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    resp_ready = 2'b10;
    @(posedge clk); #1;
    resp_ready = 2'b00;
    n_cmp++;
    if (resp_valid !== 2'b00) begin
      n_err++; $display("FAIL hold_release: got %b want 00", resp_valid);
    end
    req_valid = 2'b01;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL hold_idle_again: got %b want 01", req_ready);
    end
    req_valid = 2'b00;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_in_resp();
    @(negedge clk);
    req_valid = 2'b10;
    req_a[63:32] = 32'd1;
    req_b[63:32] = 32'd2;
    @(posedge clk); #1;
    req_valid = 2'b00;
    n_cmp++;
    if (resp_valid !== 2'b10 || resp_result !== 32'd3) begin
      n_err++; $display("FAIL rst_resp_setup: v=%b r=%h want 10/3", resp_valid, resp_result);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++;
    if (resp_valid !== 2'b00 || resp_result !== '0) begin
      n_err++; $display("FAIL rst_resp_clear: v=%b r=%h want 00/0", resp_valid, resp_result);
    end
    req_valid = 2'b11;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL rst_resp_first_grant: got %b want 01", req_ready);
    end
    req_valid = 2'b00;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_equal_non_owner();
    @(negedge clk);
    req_valid = 2'b01;
    req_a[31:0] = 32'd7;
    req_b[31:0] = 32'd7;
    req_op[2:0] = 3'd1;
    @(posedge clk); #1;
    req_valid = 2'b00;
    resp_ready = 2'b10;
    n_cmp++;
    if (resp_result !== 32'd0 || resp_equal !== 1'b1) begin
      n_err++; $display("FAIL eq_resp: r=%h e=%b want 0/1", resp_result, resp_equal);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (resp_valid !== 2'b01 || resp_equal !== 1'b1) begin
      n_err++; $display("FAIL eq_non_owner: v=%b e=%b want 01/1", resp_valid, resp_equal);
    end
    resp_ready = 2'b01;
    @(posedge clk); #1;
    n_cmp++;
    if (resp_valid !== 2'b00) begin
      n_err++; $display("FAIL eq_owner_consume: got %b want 00", resp_valid);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_illegal_op();
    @(negedge clk);
    req_valid = 2'b01;
    req_a[31:0] = 32'd9;
    req_b[31:0] = 32'd9;
    req_op[2:0] = 3'd6;
    #1;
    n_cmp++;
    if (alu_op !== 3'd6) begin
      n_err++; $display("FAIL illegal_op_pass: got %0d want 6", alu_op);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    n_cmp++;
    if (resp_result !== 32'd0 || resp_equal !== 1'b1) begin
      n_err++; $display("FAIL illegal_op_resp: r=%h e=%b want 0/1", resp_result, resp_equal);
    end
    resp_ready = 2'b01;
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_stats();
    logic [CNT_W-1:0] exp0;
`ifdef ALU_ARB_STATS_EN
    exp0 = 2'd3;
`else
    exp0 = 2'd0;
`endif
    apply_reset();
    req_a[31:0] = 32'd1;
    req_valid = 2'b01;
    resp_ready = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(posedge clk);
    end
    @(negedge clk);
    clear_inputs();
    n_cmp++;
    if (grant_cnt0 !== exp0) begin
      n_err++; $display("FAIL stats_cnt0: got %0d want %0d", grant_cnt0, exp0);
    end
    n_cmp++;
    if (grant_cnt1 !== 2'd0) begin
      n_err++; $display("FAIL stats_cnt1: got %0d want 0", grant_cnt1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_reset_in_resp();
    test_equal_non_owner();
    test_illegal_op();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
